// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Variable-latency imem, one request in flight, stale responses discarded.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_D_i,
    input  logic        flush_D_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_four_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] pc_F;
    logic [31:0] next_pc_F;
    logic [31:0] pc_req;
    logic [31:0] next_pc_req;

    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] next_hold_instr;
    logic [31:0] next_hold_pc;

    logic        req;
    logic [31:0] addr;

    logic        load;
    logic [31:0] load_instr;
    logic [31:0] load_pc;

    // Next-state, request and IF/ID delivery decode.
    always_comb begin
        next_state      = state;
        next_pc_F       = pc_F;
        next_pc_req     = pc_req;
        next_hold_instr = hold_instr;
        next_hold_pc    = hold_pc;
        req             = 1'b0;
        addr            = pc_F;
        load            = 1'b0;
        load_instr      = imem_rdata_i;
        load_pc         = pc_req;

        unique case (state)
            S_FETCH: begin
                req = 1'b1;
                if (redirect_i) begin
                    addr      = redirect_pc_i;
                    next_pc_F = redirect_pc_i + 32'd4;
                end else begin
                    addr      = pc_F;
                    next_pc_F = pc_F + 32'd4;
                end
                next_pc_req = addr;
                next_state  = S_WAIT;
            end

            S_WAIT: begin
                if (redirect_i) begin
                    next_pc_F = redirect_pc_i;
                    if (imem_rvalid_i) begin
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_DROP;
                    end
                end else if (imem_rvalid_i) begin
                    if (!stall_D_i) begin
                        load        = 1'b1;
                        load_instr  = imem_rdata_i;
                        load_pc     = pc_req;
                        req         = 1'b1;
                        addr        = pc_F;
                        next_pc_req = pc_F;
                        next_pc_F   = pc_F + 32'd4;
                    end else begin
                        next_hold_instr = imem_rdata_i;
                        next_hold_pc    = pc_req;
                        next_state      = S_HOLD;
                    end
                end
            end

            S_DROP: begin
                if (redirect_i) begin
                    next_pc_F = redirect_pc_i;
                end
                if (imem_rvalid_i) begin
                    next_state = S_FETCH;
                end
            end

            S_HOLD: begin
                if (redirect_i) begin
                    next_pc_F  = redirect_pc_i;
                    next_state = S_FETCH;
                end else if (!stall_D_i) begin
                    load       = 1'b1;
                    load_instr = hold_instr;
                    load_pc    = hold_pc;
                    next_state = S_FETCH;
                end
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Fetch FSM, PC and one-entry hold buffer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= S_FETCH;
            pc_F       <= RESET_PC;
            pc_req     <= 32'h0;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
        end else begin
            state      <= next_state;
            pc_F       <= next_pc_F;
            pc_req     <= next_pc_req;
            hold_instr <= next_hold_instr;
            hold_pc    <= next_hold_pc;
        end
    end

    // IF/ID register: flush beats stall beats load; otherwise a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            instr_D <= 32'h0;
            pc_D    <= 32'h0;
            valid_D <= 1'b0;
        end else if (flush_D_i) begin
            instr_D <= 32'h0;
            valid_D <= 1'b0;
        end else if (stall_D_i) begin
            instr_D <= instr_D;
            pc_D    <= pc_D;
            valid_D <= valid_D;
        end else if (load) begin
            instr_D <= load_instr;
            pc_D    <= load_pc;
            valid_D <= 1'b1;
        end else begin
            instr_D <= 32'h0;
            valid_D <= 1'b0;
        end
    end

    assign imem_req_o  = req & i_rst_n;
    assign imem_addr_o = addr;
    assign pc_four_D   = pc_D + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem model with programmable latency,
// request and delivery scoreboards, scenario tasks run in order.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc_four_D;
    logic        valid_D;

    int compared;
    int mismatched;

    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];

    bit          busy;
    int          cnt;
    int          lat;
    logic [31:0] paddr;
    bit          inject;
    logic        last_req;
    logic [31:0] last_addr;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .stall_D_i    (stall),
        .flush_D_i    (flush),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .instr_D      (instr_D),
        .pc_D         (pc_D),
        .pc_four_D    (pc_four_D),
        .valid_D      (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // One clock cycle: memory drives, requests are scored, IF/ID is scored.
    task automatic step();
        logic        rst_s;
        logic        stall_s;
        logic        flush_s;
        logic        real_rv;
        logic        req_s;
        logic [31:0] addr_s;
        logic [31:0] e;
        rst_s   = rst_n;
        stall_s = stall;
        flush_s = flush;
        real_rv = busy && (cnt == 1);
        rvalid  = real_rv || inject;
        rdata   = inject ? 32'hDEAD_BEEF : (real_rv ? word(paddr) : 32'h0);
        inject  = 0;
        #1;
        req_s     = imem_req;
        addr_s    = imem_addr;
        last_req  = req_s;
        last_addr = addr_s;
        if (!rst_s) begin
            compared++;
            if (req_s !== 1'b0) begin
                mismatched++;
                $display("FAIL req_in_reset: got %b want 0", req_s);
            end
        end else if (req_s) begin
            compared++;
            if (exp_req.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_req: got addr %h want none", addr_s);
            end else begin
                e = exp_req.pop_front();
                if (addr_s !== e) begin
                    mismatched++;
                    $display("FAIL req_addr: got %h want %h", addr_s, e);
                end
            end
        end
        @(posedge clk);
        if (!rst_s) begin
            busy = 0;
        end else begin
            if (real_rv) busy = 0;
            else if (busy) cnt--;
            if (req_s) begin
                compared++;
                if (busy) begin
                    mismatched++;
                    $display("FAIL outstanding: got 2 requests want 1");
                end
                busy  = 1;
                cnt   = lat;
                paddr = addr_s;
            end
        end
        @(negedge clk);
        rvalid = 1'b0;
        if (rst_s && !stall_s && !flush_s) begin
            compared++;
            if (valid_D === 1'b1) begin
                if (exp_pc.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_instr: got pc %h want none", pc_D);
                end else begin
                    e = exp_pc.pop_front();
                    if (pc_D !== e || instr_D !== word(e) ||
                        pc_four_D !== e + 32'd4) begin
                        mismatched++;
                        $display("FAIL deliver: got pc %h instr %h pc4 %h want pc %h instr %h pc4 %h",
                                 pc_D, instr_D, pc_four_D, e, word(e), e + 32'd4);
                    end
                end
            end else if (valid_D !== 1'b0 || instr_D !== 32'h0) begin
                mismatched++;
                $display("FAIL bubble: got valid %b instr %h want 0 0", valid_D, instr_D);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        compared++;
        if (instr_D !== 32'h0 || pc_D !== 32'h0 || valid_D !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: got %h %h %b want 0 0 0", instr_D, pc_D, valid_D);
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b1;
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h8);
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        step();
        compared++;
        if (valid_D !== 1'b0) begin
            mismatched++;
            $display("FAIL first_bubble: got valid %b want 0", valid_D);
        end
        step();
        step();
        compared++;
        if (pc_D !== 32'h4 || valid_D !== 1'b1) begin
            mismatched++;
            $display("FAIL seq_pc: got %h %b want 4 1", pc_D, valid_D);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (pc_D !== 32'h4 || instr_D !== word(32'h4) ||
                valid_D !== 1'b1 || last_req !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_hold: got pc %h instr %h v %b req %b want 4 %h 1 0",
                         pc_D, instr_D, valid_D, last_req, word(32'h4));
            end
        end
    endtask

    task automatic test_flush_stall();
        flush = 1'b1;
        step();
        compared++;
        if (instr_D !== 32'h0 || valid_D !== 1'b0 || pc_D !== 32'h4) begin
            mismatched++;
            $display("FAIL flush_stall: got %h %b %h want 0 0 4", instr_D, valid_D, pc_D);
        end
        flush = 1'b0;
        stall = 1'b0;
        exp_pc.push_back(32'h8);
        exp_req.push_back(32'hC);
        step();
        compared++;
        if (instr_D !== word(32'h8) || last_req !== 1'b0) begin
            mismatched++;
            $display("FAIL release: got %h req %b want %h 0", instr_D, last_req, word(32'h8));
        end
        step();
        lat = 3;
        exp_pc.push_back(32'hC);
        exp_req.push_back(32'h10);
        step();
    endtask

    task automatic test_redirect_drop();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        step();
        step();
        compared++;
        if (valid_D !== 1'b0 || last_req !== 1'b0) begin
            mismatched++;
            $display("FAIL stale_drop: got valid %b req %b want 0 0", valid_D, last_req);
        end
        exp_req.push_back(32'h100);
        step();
        lat = 1;
        exp_pc.push_back(32'h100);
        exp_req.push_back(32'h104);
        step();
        step();
        step();
        exp_pc.push_back(32'h104);
        exp_req.push_back(32'h108);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        compared++;
        if (valid_D !== 1'b0) begin
            mismatched++;
            $display("FAIL redirect_rvalid: got valid %b want 0", valid_D);
        end
    endtask

    task automatic test_redirect_fetch();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        exp_req.push_back(32'h200);
        step();
        redirect = 1'b0;
        compared++;
        if (last_req !== 1'b1 || last_addr !== 32'h200) begin
            mismatched++;
            $display("FAIL redirect_fetch: got req %b addr %h want 1 200", last_req, last_addr);
        end
        lat = 3;
        exp_pc.push_back(32'h200);
        exp_req.push_back(32'h204);
        step();
        step();
    endtask

    task automatic test_reset_mid_wait();
        rst_n = 1'b0;
        step();
        compared++;
        if (instr_D !== 32'h0 || pc_D !== 32'h0 || valid_D !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: got %h %h %b want 0 0 0", instr_D, pc_D, valid_D);
        end
        rst_n  = 1'b1;
        lat    = 1;
        inject = 1;
        exp_req.push_back(32'h0);
        step();
        compared++;
        if (valid_D !== 1'b0) begin
            mismatched++;
            $display("FAIL rvalid_in_fetch: got valid %b want 0", valid_D);
        end
        exp_pc.push_back(32'h0);
        exp_req.push_back(32'h4);
        step();
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        exp_req.push_back(32'hFFFF_FFF8);
        step();
        exp_pc.push_back(32'hFFFF_FFF8);
        exp_req.push_back(32'hFFFF_FFFC);
        step();
        exp_pc.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0);
        step();
        compared++;
        if (pc_four_D !== 32'h0 || last_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL wrap: got pc4 %h addr %h want 0 0", pc_four_D, last_addr);
        end
        exp_pc.push_back(32'h0);
        exp_req.push_back(32'h4);
        step();
        stall = 1'b1;
        step();
        stall = 1'b0;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        rvalid      = 1'b0;
        rdata       = 32'h0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        busy        = 0;
        cnt         = 0;
        lat         = 1;
        paddr       = 32'h0;
        inject      = 0;
        last_req    = 1'b0;
        last_addr   = 32'h0;

        test_reset();
        test_back_to_back();
        test_stall();
        test_flush_stall();
        test_redirect_drop();
        test_redirect_fetch();
        test_reset_mid_wait();
        test_wrap();

        compared++;
        if (exp_req.size() != 0 || exp_pc.size() != 0) begin
            mismatched++;
            $display("FAIL drained: got %0d req %0d instr left want 0 0",
                     exp_req.size(), exp_pc.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
